// File: rtl/data_bus_pkg.sv
// data_bus_pkg: size codes, adapter FSM states and byte-lane helpers shared by the data bus adapter
package data_bus_pkg;
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
   localparam logic [3:0] STRB_BYTE    = 4'b0001;
   localparam logic [3:0] STRB_HALF_LO = 4'b0011;
   localparam logic [3:0] STRB_HALF_HI = 4'b1100;
   localparam logic [3:0] STRB_WORD    = 4'b1111;
   function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
      return size == SIZE_BYTE ? STRB_BYTE << off
           : size == SIZE_HALF ? (off[1] ? STRB_HALF_HI : STRB_HALF_LO)
           : STRB_WORD;
   endfunction
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
      return size == SIZE_BYTE ? {4{d[7:0]}} : size == SIZE_HALF ? {2{d[15:0]}} : d;
   endfunction
endpackage

// File: rtl/data_bus_adapter_align.sv
// load_align_extend: shifts the addressed lanes of a bus word down and sign/zero-extends by size
module load_align_extend
   import data_bus_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   output logic [31:0] result
);
   logic [31:0] r;
   always_comb begin
      r = data >> {offset, 3'b000};
      result = size == SIZE_BYTE ? {{24{sign_ext & r[7]}}, r[7:0]}
             : size == SIZE_HALF ? {{16{sign_ext & r[15]}}, r[15:0]}
             : r;
   end
endmodule

// File: rtl/data_bus_adapter.sv
// data_bus_adapter: memory-stage load/store to word-aligned strobed bus transaction with timeout
module data_bus_adapter
   import data_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_store_data,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   input  logic        mem_load,
   input  logic        mem_store,
   input  logic        pipeline_stall,
   output logic [31:0] mem_load_data,
   output logic        mem_busy,
   output logic        mem_fault,
   output logic [31:0] ext_address,
   output logic [31:0] ext_write_data,
   output logic [3:0]  ext_strobe,
   output logic        ext_read,
   output logic        ext_write,
   input  logic        ext_ready,
   input  logic [31:0] ext_read_data
);
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   state_e        state_q, state_d;
   logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d, aligned;
   logic [3:0]    strobe_q, strobe_d;
   logic [1:0]    off_q, off_d, size_q, size_d;
   logic          sgn_q, sgn_d, rd_q, rd_d, wr_q, wr_d, fault_q, fault_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req, expired;
   load_align_extend u_align (
      .data    (ext_read_data),
      .offset  (off_q),
      .size    (size_q),
      .sign_ext(sgn_q),
      .result  (aligned)
   );
   always_comb begin
      req = mem_load | mem_store;
      expired = TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES - 1);
      state_d = state_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      strobe_d = strobe_q;
      off_d = off_q;
      size_d = size_q;
      sgn_d = sgn_q;
      rd_d = rd_q;
      wr_d = wr_q;
      buf_d = buf_q;
      cnt_d = cnt_q;
      fault_d = 1'b0;
      if (state_q == IDLE && req) begin
         state_d = REQ;
         addr_d = {mem_address[31:2], 2'b00};
         wdata_d = store_lanes(mem_size, mem_store_data);
         strobe_d = mem_store ? store_strobe(mem_size, mem_address[1:0]) : STRB_WORD;
         off_d = mem_address[1:0];
         size_d = mem_size;
         sgn_d = mem_signed;
         rd_d = mem_load;
         wr_d = mem_store;
         cnt_d = '0;
      end else if (state_q == REQ) begin
         cnt_d = cnt_q + CW'(1);
         // ready in the final allowed cycle still completes normally
         if (ext_ready || expired) begin
            state_d = DONE;
            rd_d = 1'b0;
            wr_d = 1'b0;
            buf_d = ext_ready ? (rd_q ? aligned : buf_q) : '0;
            fault_d = !ext_ready;
         end
      end else if (state_q == DONE && !pipeline_stall) begin
         state_d = IDLE;
      end
      mem_busy = (state_q == IDLE && req) || state_q == REQ;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q <= '0;
         wdata_q <= '0;
         strobe_q <= '0;
         off_q <= '0;
         size_q <= '0;
         sgn_q <= 1'b0;
         rd_q <= 1'b0;
         wr_q <= 1'b0;
         buf_q <= '0;
         cnt_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         strobe_q <= strobe_d;
         off_q <= off_d;
         size_q <= size_d;
         sgn_q <= sgn_d;
         rd_q <= rd_d;
         wr_q <= wr_d;
         buf_q <= buf_d;
         cnt_q <= cnt_d;
         fault_q <= fault_d;
      end
   end
   assign mem_load_data = buf_q;
   assign mem_fault = fault_q;
   assign ext_address = addr_q;
   assign ext_write_data = wdata_q;
   assign ext_strobe = strobe_q;
   assign ext_read = rd_q;
   assign ext_write = wr_q;
endmodule

// File: tb/tb_data_bus_adapter.sv
// tb_data_bus_adapter: vector table plus stall, timeout and reset sequences with a load-data scoreboard
module tb_data_bus_adapter;
   import data_bus_pkg::*;
   logic        clk = 1'b0;
   logic        reset, mem_signed, mem_load, mem_store, pipeline_stall, ext_ready;
   logic [31:0] mem_address, mem_store_data, ext_read_data;
   logic [1:0]  mem_size;
   logic [31:0] mem_load_data, ext_address, ext_write_data;
   logic        mem_busy, mem_fault, ext_read, ext_write;
   logic [3:0]  ext_strobe;
   int          n_chk = 0, n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_buf = '0;
   always #5 clk = ~clk;
   data_bus_adapter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .mem_address(mem_address), .mem_store_data(mem_store_data),
      .mem_size(mem_size), .mem_signed(mem_signed), .mem_load(mem_load), .mem_store(mem_store),
      .pipeline_stall(pipeline_stall), .mem_load_data(mem_load_data), .mem_busy(mem_busy),
      .mem_fault(mem_fault), .ext_address(ext_address), .ext_write_data(ext_write_data),
      .ext_strobe(ext_strobe), .ext_read(ext_read), .ext_write(ext_write),
      .ext_ready(ext_ready), .ext_read_data(ext_read_data)
   );
   typedef struct {
      logic        st;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] rdata;
      int          lat;
      logic        drop;
      logic [31:0] exp_addr;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_strb;
      logic [31:0] exp_load;
   } vec_t;
   vec_t vecs[12];
   function automatic vec_t mk(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic sgn, input logic [31:0] rdata,
                               input int lat, input logic drop, input logic [31:0] exp_addr,
                               input logic [31:0] exp_wdata, input logic [3:0] exp_strb,
                               input logic [31:0] exp_load);
      vec_t v;
      v.st = st; v.addr = addr; v.wdata = wdata; v.size = size; v.sgn = sgn; v.rdata = rdata;
      v.lat = lat; v.drop = drop; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
      v.exp_strb = exp_strb; v.exp_load = exp_load;
      return v;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic pop_chk(input string name);
      if (exp_q.size() == 0) chk({name, "_scoreboard_empty"}, 32'd1, 32'd0);
      else chk(name, mem_load_data, exp_q.pop_front());
   endtask
   task automatic run(input vec_t v);
      int busy_n, bus_n;
      mem_address = v.addr; mem_store_data = v.wdata; mem_size = v.size; mem_signed = v.sgn;
      mem_load = !v.st; mem_store = v.st; pipeline_stall = 1'b0; ext_ready = 1'b0;
      exp_q.push_back(v.st ? exp_buf : v.exp_load);
      if (!v.st) exp_buf = v.exp_load;
      #1 busy_n = int'(mem_busy);
      bus_n = 0;
      tick;
      chk("ext_address", ext_address, v.exp_addr);
      chk("ext_strobe", 32'(ext_strobe), 32'(v.exp_strb));
      chk("bus_kind", 32'({ext_read, ext_write}), v.st ? 32'd1 : 32'd2);
      if (v.st) chk("ext_write_data", ext_write_data, v.exp_wdata);
      if (v.drop) begin
         mem_load = 1'b0;
         mem_store = 1'b0;
      end
      for (int i = 1; i <= v.lat; i++) begin
         ext_ready = (i == v.lat);
         ext_read_data = v.rdata;
         #1;
         busy_n += int'(mem_busy);
         bus_n += int'(v.st ? ext_write : ext_read);
         tick;
      end
      ext_ready = 1'b0;
      ext_read_data = 32'h0BAD_0BAD;
      #1;
      chk("busy_cycles", 32'(busy_n), 32'(v.lat + 1));
      chk("bus_cycles", 32'(bus_n), 32'(v.lat));
      chk("busy_in_done", 32'(mem_busy), 32'd0);
      pop_chk("load_data");
      tick;
      mem_load = 1'b0;
      mem_store = 1'b0;
      #1 chk("bus_idle_after", 32'({ext_read, ext_write}), 32'd0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int rd_n, busy_n, n;
      vecs[0]  = mk(1, 32'h100, 32'hDEAD_BEEF, SIZE_WORD, 0, 32'h0,         3, 0, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'h0);
      vecs[1]  = mk(0, 32'h203, 32'h0,         SIZE_BYTE, 1, 32'h80FF_FF00, 1, 0, 32'h200, 32'h0,         4'b1111, 32'hFFFF_FF80);
      vecs[2]  = mk(0, 32'h202, 32'h0,         SIZE_HALF, 0, 32'h8001_0000, 2, 0, 32'h200, 32'h0,         4'b1111, 32'h0000_8001);
      vecs[3]  = mk(1, 32'h001, 32'h1234_56A5, SIZE_BYTE, 0, 32'h0,         1, 0, 32'h000, 32'hA5A5_A5A5, 4'b0010, 32'h0);
      vecs[4]  = mk(1, 32'h006, 32'hCAFE_BEEF, SIZE_HALF, 0, 32'h0,         2, 0, 32'h004, 32'hBEEF_BEEF, 4'b1100, 32'h0);
      vecs[5]  = mk(1, 32'h008, 32'h0000_1234, SIZE_HALF, 0, 32'h0,         1, 0, 32'h008, 32'h1234_1234, 4'b0011, 32'h0);
      vecs[6]  = mk(0, 32'h010, 32'h0,         SIZE_HALF, 1, 32'h1234_F00D, 3, 0, 32'h010, 32'h0,         4'b1111, 32'hFFFF_F00D);
      vecs[7]  = mk(0, 32'h011, 32'h0,         SIZE_BYTE, 0, 32'h0000_9A00, 4, 0, 32'h010, 32'h0,         4'b1111, 32'h0000_009A);
      vecs[8]  = mk(0, 32'h020, 32'h0,         SIZE_WORD, 0, 32'h89AB_CDEF, 1, 1, 32'h020, 32'h0,         4'b1111, 32'h89AB_CDEF);
      vecs[9]  = mk(0, 32'h022, 32'h0,         SIZE_BYTE, 1, 32'h007F_0000, 2, 0, 32'h020, 32'h0,         4'b1111, 32'h0000_007F);
      vecs[10] = mk(0, 32'h002, 32'h0,         SIZE_HALF, 1, 32'h8000_7FFF, 1, 0, 32'h000, 32'h0,         4'b1111, 32'hFFFF_8000);
      vecs[11] = mk(1, 32'h003, 32'h0000_00FF, SIZE_BYTE, 0, 32'h0,         1, 1, 32'h000, 32'hFFFF_FFFF, 4'b1000, 32'h0);
      reset = 1'b1; mem_load = 1'b0; mem_store = 1'b0; pipeline_stall = 1'b0; ext_ready = 1'b0;
      mem_address = '0; mem_store_data = '0; mem_size = SIZE_WORD; mem_signed = 1'b0;
      ext_read_data = '0;
      tick;
      tick;
      #1;
      chk("rst_bus_strobes", 32'({ext_read, ext_write}), 32'd0);
      chk("rst_strobe", 32'(ext_strobe), 32'd0);
      chk("rst_address", ext_address, 32'd0);
      chk("rst_write_data", ext_write_data, 32'd0);
      chk("rst_fault", 32'(mem_fault), 32'd0);
      chk("rst_load_data", mem_load_data, 32'd0);
      chk("rst_busy", 32'(mem_busy), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         run(vecs[i]);
         if (i == 2) begin
            ext_ready = 1'b1;
            ext_read_data = 32'hFFFF_FFFF;
            tick;
            tick;
            #1;
            chk("stray_ready_data", mem_load_data, exp_buf);
            chk("stray_ready_bus", 32'({ext_read, ext_write}), 32'd0);
            ext_ready = 1'b0;
         end
      end
      mem_address = 32'h40; mem_size = SIZE_WORD; mem_signed = 1'b0; mem_load = 1'b1;
      exp_q.push_back(32'h55AA_1234);
      exp_buf = 32'h55AA_1234;
      rd_n = 0;
      tick;
      ext_read_data = 32'h55AA_1234;
      #1 rd_n += int'(ext_read);
      tick;
      ext_ready = 1'b1;
      pipeline_stall = 1'b1;
      #1 rd_n += int'(ext_read);
      tick;
      ext_ready = 1'b0;
      ext_read_data = 32'h0;
      for (int i = 0; i < 5; i++) begin
         #1;
         rd_n += int'(ext_read);
         chk("stall_busy", 32'(mem_busy), 32'd0);
         chk("stall_data", mem_load_data, exp_buf);
         tick;
      end
      pipeline_stall = 1'b0;
      #1 pop_chk("stall_release_data");
      tick;
      #1 rd_n += int'(ext_read);
      chk("stall_read_cycles", 32'(rd_n), 32'd2);
      mem_load = 1'b0;
      exp_q.push_back(32'h0);
      exp_buf = 32'h0;
      mem_address = 32'h301; mem_size = SIZE_BYTE; mem_load = 1'b1;
      tick;
      busy_n = 0;
      n = 0;
      #1;
      while (!mem_fault && n < 20) begin
         busy_n += int'(mem_busy);
         n++;
         tick;
         #1;
      end
      chk("timeout_fault", 32'(mem_fault), 32'd1);
      chk("timeout_req_cycles", 32'(n), 32'd4);
      chk("timeout_req_busy", 32'(busy_n), 32'd4);
      chk("timeout_busy", 32'(mem_busy), 32'd0);
      chk("timeout_bus", 32'(ext_read), 32'd0);
      pop_chk("timeout_data");
      pipeline_stall = 1'b1;
      tick;
      #1 chk("fault_pulse_width", 32'(mem_fault), 32'd0);
      pipeline_stall = 1'b0;
      tick;
      mem_load = 1'b0;
      mem_address = 32'h500; mem_size = SIZE_WORD; mem_load = 1'b1;
      tick;
      #1 chk("rst_req_read", 32'(ext_read), 32'd1);
      reset = 1'b1;
      mem_load = 1'b0;
      tick;
      #1;
      chk("rst_req_read_drop", 32'(ext_read), 32'd0);
      chk("rst_req_strobe", 32'(ext_strobe), 32'd0);
      chk("rst_req_busy", 32'(mem_busy), 32'd0);
      chk("rst_req_fault", 32'(mem_fault), 32'd0);
      reset = 1'b0;
      exp_buf = 32'h0;
      run(vecs[3]);
      run(vecs[1]);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
